seq_event_reporter: RTL and testbench

//  Sits directly downstream of the 101 Moore sequence detector and consumes its data_out.

---
 rtl/seq_event_reporter_if.sv | 12 +
 rtl/seq_event_reporter.sv | 129 ++++++++++++
 tb/tb_seq_event_reporter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_event_reporter_if.sv
// Report handshake between the event reporter (master) and its consumer (slave).
interface seq_event_reporter_if #(
  parameter int CNT_W = 4
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;

  modport master (output rpt_valid, rpt_count, rpt_sat, input rpt_ready);
  modport slave  (input rpt_valid, rpt_count, rpt_sat, output rpt_ready);
endinterface

// File: rtl/seq_event_reporter.sv
// Counts rising edges of the 101-detector output per programmable window and
// hands each window's count to a valid/ready consumer, staging one result under back-pressure.
//
// state | meaning
// IDLE  | not counting; waits for enable to open a window
// COUNT | window open; timer counts down to 0 on the last window cycle
// STALL | finished count held in staging until the report register frees up
module seq_event_reporter #(
  parameter int CNT_W = 4,
  parameter int WIN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 det_in,
  input  logic [WIN_W-1:0]     window_len,
  seq_event_reporter_if.master rpt,
  output logic                 missed,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, COUNT, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             det_q;
  logic [WIN_W-1:0] timer;
  logic [CNT_W-1:0] ev_cnt;
  logic             ev_sat;
  logic [CNT_W-1:0] stg_cnt;
  logic             stg_sat;

  logic             event_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;
  logic [WIN_W-1:0] win_start;
  logic             can_load;

  // cnt_nxt/sat_nxt include the current cycle's event, so the last window cycle counts too
  always_comb begin
    event_hit = det_in & ~det_q;
    cnt_nxt   = ev_cnt;
    sat_nxt   = ev_sat;
    if (event_hit) begin
      if (ev_cnt == CNT_MAX) sat_nxt = 1'b1;
      else                   cnt_nxt = ev_cnt + 1'b1;
    end
    win_start = (window_len == '0) ? '0 : window_len - 1'b1;
    can_load  = ~rpt.rpt_valid | rpt.rpt_ready;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      det_q         <= 1'b0;
      timer         <= '0;
      ev_cnt        <= '0;
      ev_sat        <= 1'b0;
      stg_cnt       <= '0;
      stg_sat       <= 1'b0;
      missed        <= 1'b0;
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_count <= '0;
      rpt.rpt_sat   <= 1'b0;
    end else begin
      det_q <= det_in;
      // a load later in this block overrides the consume
      if (rpt.rpt_valid && rpt.rpt_ready) rpt.rpt_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            timer  <= win_start;
            ev_cnt <= '0;
            ev_sat <= 1'b0;
            state  <= COUNT;
          end
        end
        COUNT: begin
          if (timer == '0) begin
            if (can_load) begin
              rpt.rpt_count <= cnt_nxt;
              rpt.rpt_sat   <= sat_nxt;
              rpt.rpt_valid <= 1'b1;
              if (enable) begin
                timer  <= win_start;
                ev_cnt <= '0;
                ev_sat <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              stg_cnt <= cnt_nxt;
              stg_sat <= sat_nxt;
              state   <= STALL;
            end
          end else if (!enable) begin
            state <= IDLE;
          end else begin
            timer  <= timer - 1'b1;
            ev_cnt <= cnt_nxt;
            ev_sat <= sat_nxt;
          end
        end
        STALL: begin
          if (event_hit) missed <= 1'b1;
          if (rpt.rpt_ready) begin
            rpt.rpt_count <= stg_cnt;
            rpt.rpt_sat   <= stg_sat;
            rpt.rpt_valid <= 1'b1;
            if (enable) begin
              timer  <= win_start;
              ev_cnt <= '0;
              ev_sat <= 1'b0;
              state  <= COUNT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_event_reporter.sv
// Scenario bench for seq_event_reporter; expected reports are queued as stimulus
// is driven and popped by a monitor whenever a report is accepted.
module tb_seq_event_reporter;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             det_in = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic             missed;
  logic             busy;

  seq_event_reporter_if #(.CNT_W(CNT_W)) rpt_bus ();

  seq_event_reporter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .det_in     (det_in),
    .window_len (window_len),
    .rpt        (rpt_bus),
    .missed     (missed),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {sat, count}
  logic [CNT_W:0] exp_q[$];
  logic [CNT_W:0] mon_exp;

  always @(negedge clk) begin
    if (rst_n && rpt_bus.rpt_valid && rpt_bus.rpt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_report: got count=%0d sat=%0d, required no report", rpt_bus.rpt_count, rpt_bus.rpt_sat);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rpt_bus.rpt_sat, rpt_bus.rpt_count} !== mon_exp) begin
          n_fail++;
          $display("FAIL report_data: got sat=%0d count=%0d, required sat=%0d count=%0d",
                   rpt_bus.rpt_sat, rpt_bus.rpt_count, mon_exp[CNT_W], mon_exp[CNT_W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One window from IDLE with `pulses` separate 1-cycle det pulses starting at window cycle 0
  task automatic run_window(input int len, input int pulses, input bit keep_en);
    int exp_cnt;
    exp_cnt = (pulses > 15) ? 15 : pulses;
    exp_q.push_back({(pulses > 15) ? 1'b1 : 1'b0, 4'(exp_cnt)});
    window_len = WIN_W'(len);
    enable = 1'b1;
    det_in = 1'b0;
    step();
    for (int i = 0; i < len; i++) begin
      det_in = (i < 2 * pulses) && (i % 2 == 0);
      if (i == len - 1) enable = keep_en;
      step();
    end
    det_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rpt_bus.rpt_valid, rpt_bus.rpt_count, rpt_bus.rpt_sat, missed, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0d count=%0d sat=%0d missed=%0d busy=%0d, required all 0",
               rpt_bus.rpt_valid, rpt_bus.rpt_count, rpt_bus.rpt_sat, missed, busy);
    end
    rpt_bus.rpt_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0d, required 0", busy);
    end
  endtask

  // Detector output for input stream 10101 (overlapping Moore 101): pulses at window cycles 3 and 5
  task automatic test_basic();
    rpt_bus.rpt_ready = 1'b1;
    window_len = 8'd8;
    enable = 1'b1;
    det_in = 1'b0;
    exp_q.push_back({1'b0, 4'd2});
    step();
    for (int i = 0; i < 8; i++) begin
      det_in = (i == 3) || (i == 5);
      if (i == 7) begin
        enable = 1'b0;
        n_checks++;
        if (rpt_bus.rpt_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_valid: got valid=%0d, required 0", rpt_bus.rpt_valid);
        end
      end
      step();
    end
    det_in = 1'b0;
    n_checks++;
    if ({rpt_bus.rpt_valid, rpt_bus.rpt_sat, rpt_bus.rpt_count} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%0d sat=%0d count=%0d, required valid=1 sat=0 count=2",
               rpt_bus.rpt_valid, rpt_bus.rpt_sat, rpt_bus.rpt_count);
    end
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_pulse: got valid=%0d busy=%0d, required 0 0", rpt_bus.rpt_valid, busy);
    end
  endtask

  task automatic test_saturate();
    rpt_bus.rpt_ready = 1'b1;
    run_window(100, 20, 1'b0);
    step();
    run_window(40, 15, 1'b0);
    step();
    run_window(6, 0, 1'b0);
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL saturate_drained: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    rpt_bus.rpt_ready = 1'b0;
    window_len = 8'd4;
    enable = 1'b1;
    det_in = 1'b0;
    exp_q.push_back({1'b0, 4'd1});
    exp_q.push_back({1'b0, 4'd2});
    step();
    for (int i = 0; i < 4; i++) begin
      det_in = (i == 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      det_in = (i % 2 == 0);
      step();
    end
    det_in = 1'b1;
    step();
    det_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rpt_bus.rpt_valid, rpt_bus.rpt_count, busy, missed} !== {1'b1, 4'd1, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%0d count=%0d busy=%0d missed=%0d, required 1 1 1 1",
                 rpt_bus.rpt_valid, rpt_bus.rpt_count, busy, missed);
      end
      step();
    end
    rpt_bus.rpt_ready = 1'b1;
    enable = 1'b0;
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, rpt_bus.rpt_count} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%0d count=%0d, required valid=1 count=2",
               rpt_bus.rpt_valid, rpt_bus.rpt_count);
    end
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, busy, missed} !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_after: got valid=%0d busy=%0d missed=%0d, required 0 0 1", rpt_bus.rpt_valid, busy, missed);
    end
  endtask

  task automatic test_enable_drop();
    rpt_bus.rpt_ready = 1'b1;
    window_len = 8'd8;
    enable = 1'b1;
    det_in = 1'b0;
    step();
    det_in = 1'b1;
    step();
    det_in = 1'b0;
    step();
    enable = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      det_in = (i % 3 == 0);
      step();
    end
    det_in = 1'b0;
    n_checks++;
    if ({rpt_bus.rpt_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_idle: got valid=%0d busy=%0d, required 0 0", rpt_bus.rpt_valid, busy);
    end
  endtask

  task automatic test_len_zero();
    rpt_bus.rpt_ready = 1'b1;
    window_len = '0;
    enable = 1'b1;
    det_in = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      det_in = (i < 5);
      if (i == 7) enable = 1'b0;
      exp_q.push_back({1'b0, (i == 0) ? 4'd1 : 4'd0});
      step();
      n_checks++;
      if (rpt_bus.rpt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL len0_valid: window %0d got valid=%0d, required 1", i, rpt_bus.rpt_valid);
      end
    end
    det_in = 1'b0;
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, busy, 32'(exp_q.size())} !== {2'b00, 32'd0}) begin
      n_fail++;
      $display("FAIL len0_end: got valid=%0d busy=%0d pending=%0d, required 0 0 0", rpt_bus.rpt_valid, busy, exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    rpt_bus.rpt_ready = 1'b0;
    window_len = 8'd4;
    enable = 1'b1;
    det_in = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      det_in = (i == 1);
      step();
    end
    det_in = 1'b0;
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, rpt_bus.rpt_count, busy} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_pre: got valid=%0d count=%0d busy=%0d, required 1 1 1", rpt_bus.rpt_valid, rpt_bus.rpt_count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rpt_bus.rpt_valid, rpt_bus.rpt_count, rpt_bus.rpt_sat, missed, busy} !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got valid=%0d count=%0d sat=%0d missed=%0d busy=%0d, required all 0",
               rpt_bus.rpt_valid, rpt_bus.rpt_count, rpt_bus.rpt_sat, missed, busy);
    end
    enable = 1'b0;
    rpt_bus.rpt_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if ({rpt_bus.rpt_valid, busy, missed} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_idle: got valid=%0d busy=%0d missed=%0d, required 0 0 0", rpt_bus.rpt_valid, busy, missed);
    end
  endtask

  initial begin
    rpt_bus.rpt_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_stall();
    test_enable_drop();
    test_len_zero();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending reports, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
